// File: rtl/bcd_clock_core_if.sv
// HH:MM:SS core bundle: control/set inputs toward the core, BCD digits and strobes back.
// Latency: n/a (wiring only); all core-driven signals are registered inside the core.
// Backpressure: none; run/config_en gate timekeeping, the core never stalls its driver.
interface bcd_clock_core_if;
    logic       run;
    logic       config_en;
    logic       add_hour;
    logic       add_minute;
    logic       clr_second;
    logic [3:0] h_tens;
    logic [3:0] h_units;
    logic [3:0] m_tens;
    logic [3:0] m_units;
    logic [3:0] s_tens;
    logic [3:0] s_units;
    logic       pm;
    logic       sec_tick;
    logic       day_rollover;

    // Controller / board side: drives run, config and the set levels.
    modport master (
        output run, config_en, add_hour, add_minute, clr_second,
        input  h_tens, h_units, m_tens, m_units, s_tens, s_units,
        input  pm, sec_tick, day_rollover
    );

    // Core side.
    modport slave (
        input  run, config_en, add_hour, add_minute, clr_second,
        output h_tens, h_units, m_tens, m_units, s_tens, s_units,
        output pm, sec_tick, day_rollover
    );
endinterface

// File: rtl/bcd_clock_core.sv
// BCD time-of-day counter (HH:MM:SS) with tick prescaler, 12/24h format and edge-detected set inputs.
// Latency: digits update on the tick edge; set-input edges land one cycle after detection (2 flops).
// Backpressure: none; run=0 holds time and prescaler, config_en=1 freezes time and zeroes the prescaler.
module bcd_clock_core #(
    parameter int TICK_DIV    = 100_000_000,
    parameter bit TWELVE_HOUR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bcd_clock_core_if.slave   bus
);
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    // Hour reset value: 12 in 12h mode, 00 in 24h mode.
    localparam logic [3:0]    HT_RST     = TWELVE_HOUR ? 4'd1 : 4'd0;
    localparam logic [3:0]    HU_RST     = TWELVE_HOUR ? 4'd2 : 4'd0;

    logic [PW-1:0] presc;
    logic [3:0]    ht, hu, mt, mu, st, su;
    logic          pm_q;
    logic          sec_tick_q;
    logic          day_q;
    logic          prev_h, prev_m, prev_s;
    logic          rise_h, rise_m, rise_s;

    logic          tick;
    logic [3:0]    ht_n, hu_n, mt_n, mu_n, st_n, su_n;
    logic          pm_n;
    logic          day_n;
    logic [8:0]    sec_inc, min_inc, hr_inc;

    // Minutes/seconds increment: returns {carry_out, tens, units}, wrapping 59 -> 00.
    function automatic logic [8:0] inc_60(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 4'd5) return {1'b1, 4'd0, 4'd0};
            else           return {1'b0, t + 4'd1, 4'd0};
        end
        return {1'b0, t, u + 4'd1};
    endfunction

    // Hour increment: returns {wrap, tens, units}. Wrap is 23->00 (24h) or 11->12 (12h, pm toggles).
    function automatic logic [8:0] inc_hour(input logic [3:0] t, input logic [3:0] u);
        if (TWELVE_HOUR) begin
            if (t == 4'd1 && u == 4'd1) return {1'b1, 4'd1, 4'd2};
            if (t == 4'd1 && u == 4'd2) return {1'b0, 4'd0, 4'd1};
        end else begin
            if (t == 4'd2 && u == 4'd3) return {1'b1, 4'd0, 4'd0};
        end
        if (u == 4'd9) return {1'b0, t + 4'd1, 4'd0};
        return {1'b0, t, u + 4'd1};
    endfunction

    assign tick = bus.run & ~bus.config_en & (presc == PRESC_LAST);

    // Next-state of the time fields: tick carry chain, or config-mode set actions.
    always_comb begin
        sec_inc = inc_60(st, su);
        min_inc = inc_60(mt, mu);
        hr_inc  = inc_hour(ht, hu);
        ht_n    = ht;
        hu_n    = hu;
        mt_n    = mt;
        mu_n    = mu;
        st_n    = st;
        su_n    = su;
        pm_n    = pm_q;
        day_n   = 1'b0;
        if (tick) begin
            {st_n, su_n} = sec_inc[7:0];
            if (sec_inc[8]) begin
                {mt_n, mu_n} = min_inc[7:0];
                if (min_inc[8]) begin
                    {ht_n, hu_n} = hr_inc[7:0];
                    if (hr_inc[8]) begin
                        pm_n  = pm_q ^ TWELVE_HOUR;
                        // Midnight: 23->00 in 24h, PM->AM wrap in 12h.
                        day_n = TWELVE_HOUR ? pm_q : 1'b1;
                    end
                end
            end
        end else if (bus.config_en) begin
            if (rise_h) begin
                {ht_n, hu_n} = hr_inc[7:0];
                pm_n         = pm_q ^ (hr_inc[8] & TWELVE_HOUR);
            end
            if (rise_m) begin
                {mt_n, mu_n} = min_inc[7:0];
            end
            if (rise_s) begin
                st_n = 4'd0;
                su_n = 4'd0;
            end
        end
    end

    // Prescaler: free-runs while enabled, parked at 0 in config so exit restarts a full second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (bus.config_en) begin
            presc <= '0;
        end else if (bus.run) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    // Set-input edge detect: previous-value flops always track, edges only latched in config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_h <= 1'b0;
            prev_m <= 1'b0;
            prev_s <= 1'b0;
            rise_h <= 1'b0;
            rise_m <= 1'b0;
            rise_s <= 1'b0;
        end else begin
            prev_h <= bus.add_hour;
            prev_m <= bus.add_minute;
            prev_s <= bus.clr_second;
            rise_h <= bus.add_hour   & ~prev_h & bus.config_en;
            rise_m <= bus.add_minute & ~prev_m & bus.config_en;
            rise_s <= bus.clr_second & ~prev_s & bus.config_en;
        end
    end

    // Time registers and strobes; strobes are high for the cycle following the tick edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ht         <= HT_RST;
            hu         <= HU_RST;
            mt         <= 4'd0;
            mu         <= 4'd0;
            st         <= 4'd0;
            su         <= 4'd0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            day_q      <= 1'b0;
        end else begin
            ht         <= ht_n;
            hu         <= hu_n;
            mt         <= mt_n;
            mu         <= mu_n;
            st         <= st_n;
            su         <= su_n;
            pm_q       <= pm_n;
            sec_tick_q <= tick;
            day_q      <= day_n;
        end
    end

    assign bus.h_tens       = ht;
    assign bus.h_units      = hu;
    assign bus.m_tens       = mt;
    assign bus.m_units      = mu;
    assign bus.s_tens       = st;
    assign bus.s_units      = su;
    assign bus.pm           = pm_q;
    assign bus.sec_tick     = sec_tick_q;
    assign bus.day_rollover = day_q;
endmodule

// File: doc/bcd_clock_core.md
# bcd_clock_core

Parametrised BCD time-of-day counter for the alarm-clock design, replacing the fixed 24-hour seconds/tens chain with a complete HH:MM:SS core. It has an internal tick prescaler, a selectable 12/24-hour format, edge-detected field-setting inputs, and rollover/tick strobes. It sits between the board clock and the display/alarm-compare logic; the alarm time store is a second instance with `TICK_DIV` ignored and `run` tied low.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: `clk` cycles per second; legal range ≥ 1.
- `TWELVE_HOUR`, default 0: 0 selects 00–23 hour format; 1 selects 12, 01–11 with AM/PM flag.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 enables timekeeping; 0 holds time and prescaler.
- `config_en`  in  1  configuration mode; freezes timekeeping and enables the set inputs.
- `add_hour`  in  1  level input; each rising edge while `config_en`=1 advances hours by one.
- `add_minute`  in  1  level input; each rising edge while `config_en`=1 advances minutes by one.
- `clr_second`  in  1  level input; a rising edge while `config_en`=1 zeroes seconds.
- `h_tens`, `h_units`, `m_tens`, `m_units`, `s_tens`, `s_units`  out  4 each  BCD digits.
- `pm`  out  1  PM flag; constant 0 when `TWELVE_HOUR`=0.
- `sec_tick`  out  1  one-cycle strobe coincident with each timekeeping second advance.
- `day_rollover`  out  1  one-cycle strobe coincident with the midnight wrap.

## Operation
- **Prescaler**
  - Width is `$clog2(TICK_DIV)`, minimum 1. Counts 0..`TICK_DIV`-1 while `run`=1 and `config_en`=0.
  - At `TICK_DIV`-1 it returns to 0 and issues an internal tick.
  - It is held at 0 whenever `config_en`=1. It holds its value when `run`=0.
  - With `TICK_DIV`=1, a tick occurs every enabled cycle.
- **Carry chain on tick**
  - `s_units` counts 9→0 with carry to `s_tens`; `s_tens` counts 5→0 with carry to minutes. Minutes follow the same pattern.
  - 24h: hours count 00..23; 23:59:59 → 00:00:00 asserts `day_rollover`.
  - 12h: hours run 12,01..11. 11:59:59 → 12:00:00 toggles `pm`. The PM→AM toggle also asserts `day_rollover`.
  - Digits never hold non-BCD or out-of-range values; there is no illegal state reachable from reset.
- **Configuration**
  - Each set input has a registered previous-value flop (reset 0). A rising edge is current=1 and previous=0.
  - Edges are sampled every cycle but acted on only when `config_en`=1. A level already high at `config_en` entry does not count.
  - `add_hour` advances the hour field only. It wraps 23→00 (24h), or 11→12 with a `pm` toggle (12h). It does not assert `day_rollover`.
  - `add_minute` advances the minute field only, wrapping 59→00 with no hour carry.
  - `clr_second` sets seconds to 00. The prescaler is already 0.
  - Simultaneous edges on multiple set inputs are all applied in the same cycle.
- **Exiting config:** on `config_en` 1→0 the prescaler starts from 0, so the first tick comes `TICK_DIV` enabled cycles later.
- **Reset values**
  - 24h: 00:00:00. 12h: 12:00:00 with `pm`=0.
  - Prescaler 0; `sec_tick`=0; `day_rollover`=0; edge flops 0.
  - Reset asserted mid-operation takes effect immediately, asynchronously, from any state.

## Timing
- All outputs are registered. The tick edge updates the digits, and `sec_tick` is high for exactly the following cycle alongside the new value.
- Second-to-second period is exactly `TICK_DIV` cycles while enabled.
- A set-input rising edge sampled at edge N produces the updated field after edge N+1. This is two-flop latency: edge detect, then field update.
- `day_rollover` and `sec_tick` are high in the same cycle on the midnight wrap. Both are low in all other cycles, including during configuration.
- After `rst` deasserts synchronously to `clk`, the first tick occurs on the `TICK_DIV`-th enabled cycle.

## Test plan
- **Reset:** assert `rst` mid-count at 13:27:45 → all digits 0 immediately, without a clock edge. With `TWELVE_HOUR`=1, reset → 12:00:00, `pm`=0.
- **24h wrap:** `TICK_DIV`=4, preload 23:59:58 via config, `run`=1 → 23:59:59 after 4 cycles, then 00:00:00 after 4 more. `sec_tick` and `day_rollover` are both high in that one cycle only.
- **12h wrap:** `TWELVE_HOUR`=1 → 11:59:59 `pm`=0 ticks to 12:00:00 `pm`=1 with no `day_rollover`. 11:59:59 `pm`=1 ticks to 12:00:00 `pm`=0 with `day_rollover`=1.
- **Edge detection:** hold `add_hour` high 5 cycles with `config_en`=1 from 23:10:00 → exactly one increment to 00:10:00, no `day_rollover`. A pulse with `config_en`=0 → no change.
- **Minute wrap in config:** `add_minute` at 05:59:30 → 05:00:30 (no hour carry). `clr_second` → 05:00:00. Exit config → first `sec_tick` exactly `TICK_DIV` cycles later.
- **Run gating:** `TICK_DIV`=1 with `run` toggling → digits advance one second per `run`=1 cycle and freeze on `run`=0. 10 enabled cycles from 00:00:55 → 00:01:05.
